// File: rtl/avalon_pipe_pkg.sv
// -----------------------------------------------------------------------------
// avalon_pipe_pkg
// Shared constants and types for the Avalon-MM pipelined slave:
//   - legal ranges of READ_LATENCY and WAIT_STATES
//   - fault-injection codes selected by ERRNO (honoured only when the
//     AVS_ERRNO_EN macro is defined at build time)
//   - pipe_stage_t, one stage of the read-return shift pipeline {valid, data}
// No ports (package).
// -----------------------------------------------------------------------------
package avalon_pipe_pkg;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int WAIT_STATES_MIN  = 0;
    localparam int WAIT_STATES_MAX  = 3;

    // Widest supported data word; pipeline stages carry this many data bits
    // and the read pipe uses only the low DATASIZE of them.
    localparam int PIPE_DATA_MAX    = 64;

    localparam int ERR_NONE          = 0;
    localparam int ERR_BYTEEN        = 1;  // byteenable ignored, full-word writes
    localparam int ERR_LATE_VALID    = 2;  // readdatavalid one clock late
    localparam int ERR_STATUS_FROZEN = 3;  // status counter never increments

    typedef struct packed {
        logic                     valid;
        logic [PIPE_DATA_MAX-1:0] data;
    } pipe_stage_t;

endpackage

// File: rtl/avs_read_pipe.sv
// -----------------------------------------------------------------------------
// avs_read_pipe
// DEPTH-stage shift pipeline of {valid, data} that returns read data a fixed
// number of clocks after the read was accepted. Only the valid bits are reset,
// so an in-flight read is discarded by reset; data bits simply follow along.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears valid bits)
//   i_valid  in   read accepted this clock
//   i_data   in   word sampled from the bank at the accepting edge
//   o_valid  out  last stage valid
//   o_data   out  last stage data, forced to 0 when o_valid is low
// -----------------------------------------------------------------------------
module avs_read_pipe
    import avalon_pipe_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int DATASIZE = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                i_valid,
    input  logic [DATASIZE-1:0] i_data,
    output logic                o_valid,
    output logic [DATASIZE-1:0] o_data
);

    pipe_stage_t r_stage [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i].valid <= 1'b0;
            end
        end else begin
            r_stage[0].valid <= i_valid;
            r_stage[0].data  <= PIPE_DATA_MAX'(i_data);
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1].valid;
    assign o_data  = o_valid ? r_stage[DEPTH-1].data[DATASIZE-1:0] : '0;

endmodule

// File: rtl/avalon_pipe_slave.sv
// -----------------------------------------------------------------------------
// avalon_pipe_slave
// Avalon-MM pipelined slave: 2**ADDRSIZE-word register bank with byte-enabled
// writes, programmable wait states, fixed read latency with back-to-back read
// support. The top word is a read-only count of accepted writes.
// Build macro: AVS_ERRNO_EN -- when defined, parameter ERRNO selects an
// injected fault (see avalon_pipe_pkg ERR_* codes); when undefined, ERRNO is
// ignored and no fault logic exists.
// Ports:
//   clk_i            in   clock, rising edge
//   rst_ni           in   asynchronous active-low reset
//   address_i        in   word address
//   byteenable_i     in   per-byte write mask
//   read_i, write_i  in   transfer requests, held until accepted
//   writedata_i      in   write data
//   waitrequest_o    out  stall, combinational
//   readdata_o       out  read data, 0 when readdatavalid_o is low
//   readdatavalid_o  out  one-cycle pulse per accepted read
// -----------------------------------------------------------------------------
module avalon_pipe_slave
    import avalon_pipe_pkg::*;
#(
    parameter int ADDRSIZE     = 3,
    parameter int DATASIZE     = 16,
    parameter int READ_LATENCY = 2,
    parameter int WAIT_STATES  = 0,
    parameter int ERRNO        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDRSIZE-1:0]   address_i,
    input  logic [DATASIZE/8-1:0] byteenable_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [DATASIZE-1:0]   writedata_i,
    output logic                  waitrequest_o,
    output logic [DATASIZE-1:0]   readdata_o,
    output logic                  readdatavalid_o
);

    localparam int                  NWORDS      = 2**ADDRSIZE;
    localparam int                  NBYTES      = DATASIZE/8;
    localparam logic [ADDRSIZE-1:0] STATUS_ADDR = ADDRSIZE'(NWORDS-1);
    localparam logic [1:0]          WS_LAST     = 2'(WAIT_STATES);

`ifdef AVS_ERRNO_EN
    localparam bit LP_FAULT_BYTEEN = (ERRNO == ERR_BYTEEN);
    localparam bit LP_FAULT_LATE   = (ERRNO == ERR_LATE_VALID);
    localparam bit LP_FAULT_FROZEN = (ERRNO == ERR_STATUS_FROZEN);
`else
    localparam bit LP_FAULT_BYTEEN = 1'b0;
    localparam bit LP_FAULT_LATE   = 1'b0;
    localparam bit LP_FAULT_FROZEN = 1'b0;
`endif

    localparam int PIPE_DEPTH = READ_LATENCY + (LP_FAULT_LATE ? 1 : 0);

    logic [1:0]          r_cnt;
    logic [DATASIZE-1:0] r_bank [NWORDS];
    logic [DATASIZE-1:0] r_status;
    logic                w_req;
    logic                w_accept;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [DATASIZE-1:0] w_rd_word;

    assign w_req         = read_i | write_i;
    assign waitrequest_o = w_req & (r_cnt != WS_LAST);
    assign w_accept      = w_req & ~waitrequest_o;
    assign w_wr_acc      = w_accept & write_i;
    // A simultaneous read+write is a protocol violation: only the write happens.
    assign w_rd_acc      = w_accept & read_i & ~write_i;

    // Wait counter: counts stalled cycles of the pending request; restarts
    // from zero for every new transfer or when the request is withdrawn.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (!w_req || w_accept) begin
            r_cnt <= '0;
        end else if (r_cnt != WS_LAST) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Register bank. The top entry is never written; reads of that address
    // are steered to the status counter instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_wr_acc && (address_i != STATUS_ADDR)) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (LP_FAULT_BYTEEN || byteenable_i[k]) begin
                    r_bank[address_i][8*k +: 8] <= writedata_i[8*k +: 8];
                end
            end
        end
    end

    // Accepted-write counter; every accepted write counts, including writes
    // aimed at the status word itself. Wraps naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_status <= '0;
        end else if (w_wr_acc && !LP_FAULT_FROZEN) begin
            r_status <= r_status + DATASIZE'(1);
        end
    end

    assign w_rd_word = (address_i == STATUS_ADDR) ? r_status : r_bank[address_i];

    avs_read_pipe #(
        .DEPTH    (PIPE_DEPTH),
        .DATASIZE (DATASIZE)
    ) u_read_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_valid (w_rd_acc),
        .i_data  (w_rd_word),
        .o_valid (readdatavalid_o),
        .o_data  (readdata_o)
    );

endmodule

// File: tb/tb_avalon_pipe_slave.sv
// -----------------------------------------------------------------------------
// tb_avalon_pipe_slave
// Three instances of avalon_pipe_slave (ADDRSIZE=3, DATASIZE=16):
//   index 0: READ_LATENCY=2, WAIT_STATES=0
//   index 1: READ_LATENCY=3, WAIT_STATES=0
//   index 2: READ_LATENCY=1, WAIT_STATES=2
// A behavioural model (word array, write counter, queue of expected returns
// with due cycle) predicts every read return and every wait-state count.
// -----------------------------------------------------------------------------
module tb_avalon_pipe_slave;

    localparam int LAT_T [3] = '{2, 3, 1};
    localparam int WS_T  [3] = '{0, 0, 2};

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [2:0]  addr  [3];
    logic [1:0]  be    [3];
    logic [15:0] wdat  [3];
    logic        wreq  [3];
    logic        rvld  [3];
    logic [15:0] rdat  [3];

    always #5 clk = ~clk;

    avalon_pipe_slave #(.ADDRSIZE(3), .DATASIZE(16), .READ_LATENCY(2), .WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .address_i(addr[0]), .byteenable_i(be[0]),
        .read_i(rd[0]), .write_i(wr[0]), .writedata_i(wdat[0]),
        .waitrequest_o(wreq[0]), .readdata_o(rdat[0]), .readdatavalid_o(rvld[0]));

    avalon_pipe_slave #(.ADDRSIZE(3), .DATASIZE(16), .READ_LATENCY(3), .WAIT_STATES(0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .address_i(addr[1]), .byteenable_i(be[1]),
        .read_i(rd[1]), .write_i(wr[1]), .writedata_i(wdat[1]),
        .waitrequest_o(wreq[1]), .readdata_o(rdat[1]), .readdatavalid_o(rvld[1]));

    avalon_pipe_slave #(.ADDRSIZE(3), .DATASIZE(16), .READ_LATENCY(1), .WAIT_STATES(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .address_i(addr[2]), .byteenable_i(be[2]),
        .read_i(rd[2]), .write_i(wr[2]), .writedata_i(wdat[2]),
        .waitrequest_o(wreq[2]), .readdata_o(rdat[2]), .readdatavalid_o(rvld[2]));

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;

    logic [15:0] mem  [3][8];
    logic [15:0] stat [3];
    exp_t        expq [3][$];

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic model_clear(input int d);
        for (int a = 0; a < 8; a++) mem[d][a] = '0;
        stat[d] = '0;
        expq[d].delete();
    endtask

    task automatic model_accept(input int d, input bit w, input bit r, input logic [2:0] a,
                                input logic [1:0] b, input logic [15:0] wd);
        exp_t e;
        if (w) begin
            if (a != 3'd7) begin
                if (b[0]) mem[d][a][7:0]  = wd[7:0];
                if (b[1]) mem[d][a][15:8] = wd[15:8];
            end
            stat[d] = stat[d] + 16'd1;
        end else if (r) begin
            e.due  = cyc + LAT_T[d];
            e.data = (a == 3'd7) ? stat[d] : mem[d][a];
            expq[d].push_back(e);
        end
    endtask

    // Read-return monitor: every cycle each DUT either returns the predicted
    // word exactly on its due cycle or shows valid=0 / data=0.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (expq[d].size() > 0 && expq[d][0].due == cyc) begin
                    check($sformatf("rdvalid_d%0d_c%0d", d, cyc), 32'(rvld[d]), 32'd1);
                    check($sformatf("rdata_d%0d_c%0d", d, cyc), 32'(rdat[d]), 32'(expq[d][0].data));
                    void'(expq[d].pop_front());
                end else begin
                    check($sformatf("idle_valid_d%0d_c%0d", d, cyc), 32'(rvld[d]), 32'd0);
                    check($sformatf("idle_data_d%0d_c%0d", d, cyc), 32'(rdat[d]), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after acceptance
    // with the request still asserted (so calls can be chained back-to-back).
    task automatic xfer(input int d, input bit w, input bit r, input logic [2:0] a,
                        input logic [1:0] b, input logic [15:0] wd);
        int waits;
        bit done;
        wr[d] = w; rd[d] = r; addr[d] = a; be[d] = b; wdat[d] = wd;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (wreq[d] === 1'b0) begin
                done = 1'b1;
                model_accept(d, w, r, a, b, wd);
            end else begin
                waits++;
            end
            @(negedge clk);
        end
        if (done) check($sformatf("waits_d%0d_a%0d", d, a), 32'(waits), 32'(WS_T[d]));
        else      check($sformatf("accept_timeout_d%0d", d), 32'd0, 32'd1);
    endtask

    task automatic idle(input int d);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0;
        model_clear(d);
        #1;
        check($sformatf("rst_waitreq_d%0d", d), 32'(wreq[d]),
              32'((rd[d] | wr[d]) & (WS_T[d] != 0)));
        check($sformatf("rst_valid_d%0d", d), 32'(rvld[d]), 32'd0);
        check($sformatf("rst_data_d%0d", d), 32'(rdat[d]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[d] = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; be[d] = '0; wdat[d] = '0;
            model_clear(d);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_waitreq_d%0d", d), 32'(wreq[d]), 32'd0);
            check($sformatf("reset_valid_d%0d", d), 32'(rvld[d]), 32'd0);
            check($sformatf("reset_data_d%0d", d), 32'(rdat[d]), 32'd0);
        end
        // waitrequest during reset follows the request only when wait states exist
        rd[0] = 1'b1; rd[2] = 1'b1;
        #1;
        check("reset_waitreq_req_ws0", 32'(wreq[0]), 32'd0);
        check("reset_waitreq_req_ws2", 32'(wreq[2]), 32'd1);
        rd[0] = 1'b0; rd[2] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);

        // Write 0xBEEF, read back with latency 2
        xfer(0, 1, 0, 3'd2, 2'b11, 16'hBEEF);
        xfer(0, 0, 1, 3'd2, 2'b11, 16'h0000);
        idle(0);
        repeat (3) @(negedge clk);

        // Byte-enabled partial write, read immediately after the write
        xfer(0, 1, 0, 3'd1, 2'b11, 16'h1234);
        xfer(0, 1, 0, 3'd1, 2'b01, 16'hABCD);
        xfer(0, 0, 1, 3'd1, 2'b00, 16'h0000);
        idle(0);
        repeat (3) @(negedge clk);

        // Empty byteenable, simultaneous read+write, write to status word
        xfer(0, 1, 0, 3'd1, 2'b00, 16'hFFFF);
        xfer(0, 1, 1, 3'd3, 2'b11, 16'h5A5A);
        xfer(0, 1, 0, 3'd7, 2'b11, 16'hFFFF);
        xfer(0, 0, 1, 3'd1, 2'b00, 16'h0000);
        xfer(0, 0, 1, 3'd3, 2'b00, 16'h0000);
        xfer(0, 0, 1, 3'd7, 2'b00, 16'h0000);
        idle(0);
        repeat (4) @(negedge clk);

        // Wait states = 2: first write, then status word reads 1
        xfer(2, 1, 0, 3'd0, 2'b11, 16'hC0DE);
        xfer(2, 0, 1, 3'd7, 2'b00, 16'h0000);
        idle(2);
        repeat (3) @(negedge clk);

        // Latency 3: four back-to-back reads
        for (int i = 0; i < 4; i++) xfer(1, 1, 0, 3'(i), 2'b11, 16'h1100 + 16'(i));
        for (int i = 0; i < 4; i++) xfer(1, 0, 1, 3'(i), 2'b00, 16'h0000);
        idle(1);
        repeat (5) @(negedge clk);

        // Reset one clock after a read is accepted: the read is discarded
        xfer(0, 0, 1, 3'd2, 2'b00, 16'h0000);
        idle(0);
        @(posedge clk);
        #1;
        do_reset(0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) xfer(0, 0, 1, 3'(i), 2'b00, 16'h0000);
        idle(0);
        repeat (4) @(negedge clk);

        // Reset while a request is stalled: wait counting restarts from zero
        wr[2] = 1'b1; addr[2] = 3'd4; be[2] = 2'b11; wdat[2] = 16'h7777;
        @(posedge clk);
        #1;
        do_reset(2);
        xfer(2, 1, 0, 3'd4, 2'b11, 16'h7777);
        xfer(2, 0, 1, 3'd4, 2'b00, 16'h0000);
        idle(2);
        repeat (3) @(negedge clk);

        // Randomised traffic against the model on every instance
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                int op;
                op = int'($urandom_range(0, 9));
                if (op <= 3)      xfer(d, 1, 0, 3'($urandom_range(0, 7)), 2'($urandom), 16'($urandom));
                else if (op <= 7) xfer(d, 0, 1, 3'($urandom_range(0, 7)), 2'b00, 16'h0000);
                else if (op == 8) xfer(d, 1, 1, 3'($urandom_range(0, 7)), 2'($urandom), 16'($urandom));
                else begin
                    idle(d);
                    @(negedge clk);
                end
            end
            idle(d);
            for (int a = 0; a < 8; a++) xfer(d, 0, 1, 3'(a), 2'b00, 16'h0000);
            idle(d);
            repeat (6) @(negedge clk);
        end

        for (int d = 0; d < 3; d++)
            check($sformatf("drained_d%0d", d), 32'(expq[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_pipe_slave.md
AVALON_PIPE_SLAVE -- requirements
Module: avalon_pipe_slave

Interface
REQ-001 Parameter ADDRSIZE, default 3, word-address width; the register bank holds 2**ADDRSIZE words.
REQ-002 Parameter DATASIZE, default 16, data width; SHALL be a multiple of 8, range 8..64.
REQ-003 Parameter READ_LATENCY, default 2, accept-to-readdatavalid delay in clocks; range 1..4.
REQ-004 Parameter WAIT_STATES, default 0, waitrequest cycles inserted per transfer; range 0..3.
REQ-005 Parameter ERRNO, default 0, selects an injected fault; active only with the macro from REQ-025.
REQ-006 clk_i  in  1  single clock; all state updates on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 address_i  in  ADDRSIZE  word address.
REQ-009 byteenable_i  in  DATASIZE/8  per-byte write mask; bit k covers bits 8k+7..8k.
REQ-010 read_i / write_i  in  1 each  transfer request, held until waitrequest_o is low at a rising edge.
REQ-011 writedata_i  in  DATASIZE  write data.
REQ-012 waitrequest_o  out  1  stall; a transfer is accepted at a rising edge where a request is high and waitrequest_o is low.
REQ-013 readdata_o  out  DATASIZE  read data, 0 whenever readdatavalid_o is low.
REQ-014 readdatavalid_o  out  1  one-cycle pulse per accepted read.

Function
REQ-015 Wait counter cnt (0..WAIT_STATES): waitrequest_o = (read_i|write_i) & (cnt != WAIT_STATES), combinational; cnt increments each clock while a request is pending and cnt < WAIT_STATES; cnt clears on acceptance or when the request drops.
REQ-016 WAIT_STATES=0: waitrequest_o stays 0; one transfer accepted per clock.
REQ-017 Accepted write: each word byte with byteenable bit set takes writedata_i; other bytes are held; byteenable all-zero is accepted with no effect.
REQ-018 Accepted read: data is sampled from the bank at the accepting edge and enters a READ_LATENCY-deep shift pipeline of {valid, data}; readdatavalid_o is high exactly READ_LATENCY clocks after acceptance.
REQ-019 Back-to-back reads SHALL produce back-to-back readdatavalid_o pulses in order; no overflow is possible, at most READ_LATENCY reads are in flight.
REQ-020 Write at edge t followed by a read of the same address accepted at edge t+1 SHALL return the new data.
REQ-021 read_i and write_i both high is a protocol violation: the write is performed, the read is dropped, and no readdatavalid_o pulse follows.
REQ-022 Address 2**ADDRSIZE-1 is the read-only status word: accepted-write counter, DATASIZE bits, wraps to 0 after all-ones; writes to it are accepted, count, and do not change it except by the increment.

Reset
REQ-023 While rst_ni=0: bank words and counter = 0, cnt = 0, pipeline valid bits = 0, readdatavalid_o = 0, readdata_o = 0, waitrequest_o = (read_i|write_i) & (WAIT_STATES != 0).
REQ-024 Reset asserted mid-transfer aborts it: in-flight reads are discarded and no readdatavalid_o pulse follows release; the first rising edge after release behaves as cnt = 0.

Configuration
REQ-025 Macro AVS_ERRNO_EN defined: ERRNO=1 ignores byteenable_i (full-word writes), ERRNO=2 delays readdatavalid_o by one extra clock, ERRNO=3 leaves the status counter frozen; other values behave normally. Macro undefined: ERRNO is ignored and no fault logic is synthesised.

Structure
REQ-026 Package avalon_pipe_pkg holds the range limits of READ_LATENCY and WAIT_STATES, the ERRNO code constants, and the pipeline-stage struct typedef {valid, data}.
REQ-027 One sub-module avs_read_pipe (the parametrised shift pipeline); bank, wait counter and status counter stay in the top level.

Verification (ADDRSIZE=3, DATASIZE=16 unless noted)
REQ-028 LAT=2, WS=0: write 0xBEEF to addr 2 with byteenable 11, read addr 2 -> readdatavalid_o two clocks after read acceptance, readdata_o=0xBEEF.
REQ-029 Write 0x1234 to addr 1, then write 0xABCD with byteenable 01, read addr 1 -> 0x12CD.
REQ-030 WS=2: write held -> waitrequest_o high exactly 2 cycles, accepted on the 3rd edge; read of addr 7 then returns 0x0001.
REQ-031 LAT=3: four back-to-back reads of addrs 0..3 -> four consecutive valid pulses, in order.
REQ-032 Read accepted, rst_ni pulsed low one clock later -> no readdatavalid_o pulse; all words read back 0.
REQ-033 With AVS_ERRNO_EN defined and ERRNO=1, REQ-029 stimulus -> 0xABCD; undefined -> 0x12CD.
